// File: rtl/pum_xbox_mem.sv
// Responder end of the PUM xbox port: single-port row memory with a fixed-latency
// read handshake, illegal-request flagging and saturating access counters.
module pum_xbox_mem #(
  parameter int DATA_W = 1024,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              xbox_rd,
  input  logic              xbox_wr,
  input  logic [ADDR_W-1:0] xbox_addr,
  input  logic [DATA_W-1:0] xbox_wdata,
  output logic              xbox_ready,
  output logic [DATA_W-1:0] xbox_rdata,
  output logic              xbox_rvalid,
  output logic              xbox_err,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_legal;
  logic [LAT_W-1:0]  lat_cnt;
  logic              addr_legal;
  logic              req_any;
  logic              req_both;
  logic              acc_rd;
  logic              acc_wr;

  always_comb begin
    addr_legal = ({1'b0, xbox_addr} < DEPTH_X);
    req_any    = xbox_rd | xbox_wr;
    req_both   = xbox_rd & xbox_wr;
    acc_rd     = xbox_ready & xbox_rd & ~xbox_wr;
    acc_wr     = xbox_ready & xbox_wr & ~xbox_rd;
  end

  // Array kept out of the reset domain: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (acc_wr && addr_legal)
      mem[xbox_addr[IDX_W-1:0]] <= xbox_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      xbox_ready  <= 1'b1;
      xbox_rvalid <= 1'b0;
      xbox_err    <= 1'b0;
      xbox_rdata  <= '0;
      rd_count    <= '0;
      wr_count    <= '0;
      rd_idx      <= '0;
      rd_legal    <= 1'b0;
      lat_cnt     <= '0;
    end else begin
      xbox_rvalid <= 1'b0;
      xbox_err    <= 1'b0;

      if (acc_rd && (rd_count != '1))
        rd_count <= rd_count + 1'b1;
      if (acc_wr && (wr_count != '1))
        wr_count <= wr_count + 1'b1;

      case (state)
        IDLE: begin
          if (req_both) begin
            xbox_err <= 1'b1;
          end else if (acc_wr) begin
            xbox_err <= ~addr_legal;
          end else if (acc_rd) begin
            if (RD_LAT == 1) begin
              xbox_rvalid <= 1'b1;
              xbox_rdata  <= addr_legal ? mem[xbox_addr[IDX_W-1:0]] : '0;
              xbox_err    <= ~addr_legal;
            end else begin
              state      <= RD_WAIT;
              xbox_ready <= 1'b0;
              lat_cnt    <= LAT_W'(RD_LAT - 1);
              rd_idx     <= xbox_addr[IDX_W-1:0];
              rd_legal   <= addr_legal;
            end
          end
        end
        RD_WAIT: begin
          // Strobes while busy are dropped but still flagged next cycle.
          xbox_err <= req_any;
          if (lat_cnt == LAT_W'(1)) begin
            state       <= IDLE;
            xbox_ready  <= 1'b1;
            xbox_rvalid <= 1'b1;
            xbox_rdata  <= rd_legal ? mem[rd_idx] : '0;
            if (!rd_legal)
              xbox_err <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pum_xbox_mem.sv
// Scoreboard bench for pum_xbox_mem: default build plus a narrow RD_LAT=1 / CNT_W=4 build.
module tb_pum_xbox_mem;
  localparam int DW = 1024;
  localparam int AW = 14;
  localparam int DEPTH = 1024;
  localparam int RL = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          xbox_rd = 1'b0;
  logic          xbox_wr = 1'b0;
  logic [AW-1:0] xbox_addr = '0;
  logic [DW-1:0] xbox_wdata = '0;
  logic          xbox_ready;
  logic          xbox_rvalid;
  logic          xbox_err;
  logic [DW-1:0] xbox_rdata;
  logic [CW-1:0] rd_count;
  logic [CW-1:0] wr_count;

  logic        s_rd = 1'b0;
  logic        s_wr = 1'b0;
  logic [4:0]  s_addr = '0;
  logic [31:0] s_wdata = '0;
  logic        s_ready;
  logic        s_rvalid;
  logic        s_err;
  logic [31:0] s_rdata;
  logic [3:0]  s_rd_count;
  logic [3:0]  s_wr_count;

  always #5 clk = ~clk;

  pum_xbox_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(RL), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .xbox_rd(xbox_rd), .xbox_wr(xbox_wr),
    .xbox_addr(xbox_addr), .xbox_wdata(xbox_wdata), .xbox_ready(xbox_ready),
    .xbox_rdata(xbox_rdata), .xbox_rvalid(xbox_rvalid), .xbox_err(xbox_err),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  pum_xbox_mem #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .RD_LAT(1), .CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .xbox_rd(s_rd), .xbox_wr(s_wr),
    .xbox_addr(s_addr), .xbox_wdata(s_wdata), .xbox_ready(s_ready),
    .xbox_rdata(s_rdata), .xbox_rvalid(s_rvalid), .xbox_err(s_err),
    .rd_count(s_rd_count), .wr_count(s_wr_count)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (low 128 bits) cycle %0d", tag, obs[127:0], exp[127:0], cyc);
    end
  endtask

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          expq[$];
  bit            err_due[int];
  logic [DW-1:0] mm[int];
  int            busy_until = 0;
  int            rd_exp = 0;
  int            wr_exp = 0;
  bit            mon_en = 1'b0;

  always @(negedge clk) begin
    bit exp_rv;
    bit exp_err;
    if (mon_en) begin
      exp_rv = (expq.size() > 0) && (expq[0].due == cyc);
      check("rvalid", DW'(xbox_rvalid), DW'(exp_rv));
      if (exp_rv) begin
        check("rdata", xbox_rdata, expq[0].data);
        void'(expq.pop_front());
      end
      exp_err = err_due.exists(cyc);
      if (exp_err) err_due.delete(cyc);
      check("err", DW'(xbox_err), DW'(exp_err));
    end
  end

  task automatic req(input logic rd, input logic wr, input int addr, input logic [DW-1:0] wd);
    int   c;
    bit   rdy;
    rsp_t r;
    @(negedge clk);
    c   = cyc;
    rdy = (c >= busy_until);
    check("ready", DW'(xbox_ready), DW'(rdy));
    xbox_rd    = rd;
    xbox_wr    = wr;
    xbox_addr  = AW'(addr);
    xbox_wdata = wd;
    if (rd || wr) begin
      if (!rdy || (rd && wr)) begin
        err_due[c+1] = 1'b1;
      end else if (wr) begin
        if (wr_exp < 65535) wr_exp++;
        if (addr < DEPTH) mm[addr] = wd;
        else err_due[c+1] = 1'b1;
      end else begin
        if (rd_exp < 65535) rd_exp++;
        r.due  = c + RL;
        r.data = (addr < DEPTH) ? mm[addr] : '0;
        if (addr >= DEPTH) err_due[c+RL] = 1'b1;
        busy_until = c + RL;
        expq.push_back(r);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) req(1'b0, 1'b0, 0, '0);
  endtask

  task automatic cnt_chk();
    check("rd_count", DW'(rd_count), DW'(rd_exp));
    check("wr_count", DW'(wr_count), DW'(wr_exp));
  endtask

  function automatic logic [DW-1:0] rnd_row();
    logic [DW-1:0] v;
    for (int w = 0; w < DW/32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] row5;
    logic [DW-1:0] row3;
    row5 = {32{32'hA5A5_0001}};
    row3 = {32{32'h0BAD_C0DE}};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", DW'(xbox_ready), DW'(1));
    check("rst_rvalid", DW'(xbox_rvalid), '0);
    check("rst_err", DW'(xbox_err), '0);
    check("rst_rdata", xbox_rdata, '0);
    check("rst_rd_count", DW'(rd_count), '0);
    check("rst_wr_count", DW'(wr_count), '0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // 1: write then read row 5
    req(1'b0, 1'b1, 5, row5);
    req(1'b1, 1'b0, 5, '0);
    idle(3);
    cnt_chk();
    check("rdata_hold", xbox_rdata, row5);

    // 2: rd+wr together dropped, row 3 preserved
    req(1'b0, 1'b1, 3, row3);
    req(1'b1, 1'b1, 3, ~row3);
    idle(1);
    cnt_chk();
    req(1'b1, 1'b0, 3, '0);
    idle(3);

    // 3: out-of-range read and write
    req(1'b1, 1'b0, 1024, '0);
    idle(3);
    req(1'b0, 1'b1, 2000, row5);
    idle(2);
    cnt_chk();

    // 4: request while busy, then read issued in the rvalid cycle
    req(1'b0, 1'b1, 7, rnd_row());
    req(1'b0, 1'b1, 8, rnd_row());
    req(1'b1, 1'b0, 7, '0);
    req(1'b1, 1'b0, 8, '0);
    req(1'b1, 1'b0, 8, '0);
    idle(3);
    cnt_chk();

    // Back-to-back writes, then reads pipelined into each rvalid cycle
    for (int i = 0; i < 8; i++) req(1'b0, 1'b1, 100 + i, rnd_row());
    for (int i = 0; i < 8; i++) begin
      req(1'b1, 1'b0, 107 - i, '0);
      idle(1);
    end
    idle(2);
    cnt_chk();

    // 5: reset in cycle 1 of a read
    req(1'b1, 1'b0, 5, '0);
    @(negedge clk);
    xbox_rd = 1'b0;
    rst_n   = 1'b0;
    expq.delete();
    err_due.delete();
    busy_until = 0;
    rd_exp = 0;
    wr_exp = 0;
    @(negedge clk);
    check("mrst_ready", DW'(xbox_ready), DW'(1));
    check("mrst_rvalid", DW'(xbox_rvalid), '0);
    cnt_chk();
    rst_n = 1'b1;
    idle(4);
    cnt_chk();

    // 6: narrow build, counter saturation and single-cycle read latency
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check("s_wr_count", DW'(s_wr_count), DW'((i > 15) ? 15 : i));
      s_wr    = 1'b1;
      s_addr  = 5'(i % 16);
      s_wdata = 32'h1000 + 32'(i);
    end
    @(negedge clk);
    s_wr = 1'b0;
    check("s_wr_sat", DW'(s_wr_count), DW'(15));
    check("s_ready_wr", DW'(s_ready), DW'(1));
    s_rd   = 1'b1;
    s_addr = 5'd15;
    @(negedge clk);
    s_addr = 5'd0;
    check("s_rvalid1", DW'(s_rvalid), DW'(1));
    check("s_rdata1", DW'(s_rdata), DW'(32'h100F));
    check("s_err1", DW'(s_err), '0);
    check("s_ready_rd", DW'(s_ready), DW'(1));
    @(negedge clk);
    s_addr = 5'd20;
    check("s_rdata0", DW'(s_rdata), DW'(32'h1010));
    check("s_rvalid_b2b", DW'(s_rvalid), DW'(1));
    @(negedge clk);
    s_rd = 1'b0;
    check("s_oob_rvalid", DW'(s_rvalid), DW'(1));
    check("s_oob_rdata", DW'(s_rdata), '0);
    check("s_oob_err", DW'(s_err), DW'(1));
    check("s_rd_count", DW'(s_rd_count), DW'(3));
    @(negedge clk);
    check("s_rvalid_low", DW'(s_rvalid), '0);
    check("s_wr_hold", DW'(s_wr_count), DW'(15));

    idle(2);
    check("sb_empty", DW'(expq.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
